// File: rtl/fpu_int_to_float_seq.sv
//==============================================================================
// Module      : fpu_int_to_float_seq
// Description : Multi-cycle int32/uint32 to IEEE-754 single-precision converter
//               (FCVT.S.W / FCVT.S.WU). The magnitude is normalised with coarse
//               then single-bit left shifts, one per cycle. It is then rounded
//               with the shared G/R/S rules. Valid/ready on both sides, and
//               only one conversion is in flight at a time.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fpu_int_to_float_seq #(
    parameter int BIAS         = 127,
    parameter int COARSE_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_int,
    input  logic [2:0]  in_rm,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic        out_inexact_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Exponent of a magnitude whose leading one sits in bit 31.
    localparam logic [7:0] c_EXP_INIT = 8'(BIAS + 31);
    localparam logic [7:0] c_COARSE   = 8'(COARSE_SHIFT);

    localparam logic [2:0] c_RM_RNE = 3'b000;
    localparam logic [2:0] c_RM_RTZ = 3'b001;
    localparam logic [2:0] c_RM_RDN = 3'b010;
    localparam logic [2:0] c_RM_RUP = 3'b011;
    localparam logic [2:0] c_RM_RMM = 3'b100;

    state_t      r_state;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic        r_sign;
    logic [2:0]  r_rm;

    logic        w_neg;
    logic [31:0] w_mag;
    logic        w_coarse_zero;
    logic [22:0] w_frac;
    logic        w_g;
    logic        w_r;
    logic        w_s;
    logic        w_grs;
    logic        w_inc;
    logic [23:0] w_sum;

    // Operand magnitude; the two's complement of 0x80000000 is itself, which is
    // exactly the unsigned magnitude 2^31.
    assign w_neg = in_signed & in_int[31];
    assign w_mag = w_neg ? (~in_int + 32'd1) : in_int;

    // A coarse step is taken only while the whole top group is clear, so the
    // leading one can never be shifted out.
    assign w_coarse_zero = (r_mag[31 -: COARSE_SHIFT] == '0);

    assign w_frac = r_mag[30:8];
    assign w_g    = r_mag[7];
    assign w_r    = r_mag[6];
    assign w_s    = |r_mag[5:0];
    assign w_grs  = w_g | w_r | w_s;

    // Round-increment decision; reserved modes truncate.
    always_comb begin
        w_inc = 1'b0;
        case (r_rm)
            c_RM_RNE: w_inc = w_g & (w_r | w_s | w_frac[0]);
            c_RM_RTZ: w_inc = 1'b0;
            c_RM_RDN: w_inc = w_grs & r_sign;
            c_RM_RUP: w_inc = w_grs & ~r_sign;
            c_RM_RMM: w_inc = w_g;
            default:  w_inc = 1'b0;
        endcase
    end

    // On mantissa carry the low 23 bits of the sum are already zero.
    assign w_sum = {1'b0, w_frac} + {23'd0, w_inc};

    // Control FSM with datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_mag            <= '0;
            r_exp            <= '0;
            r_sign           <= 1'b0;
            r_rm             <= '0;
            in_ready         <= 1'b1;
            out_valid        <= 1'b0;
            out_float        <= '0;
            out_inexact_flag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_rm     <= in_rm;
                        r_sign   <= w_neg;
                        r_mag    <= w_mag;
                        r_exp    <= c_EXP_INIT;
                        in_ready <= 1'b0;
                        if (w_mag == 32'd0) begin
                            out_float        <= '0;
                            out_inexact_flag <= 1'b0;
                            r_state          <= DONE;
                        end else begin
                            r_state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (w_coarse_zero) begin
                        r_mag <= r_mag << COARSE_SHIFT;
                        r_exp <= r_exp - c_COARSE;
                    end else if (!r_mag[31]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 8'd1;
                    end else begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    out_float        <= {r_sign, (w_sum[23] ? r_exp + 8'd1 : r_exp), w_sum[22:0]};
                    out_inexact_flag <= w_grs;
                    out_valid        <= 1'b1;
                    r_state          <= DONE;
                end
                DONE: begin
                    // The zero path enters DONE without out_valid and raises it here.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_int_to_float_seq.sv
//==============================================================================
// Module      : tb_fpu_int_to_float_seq
// Description : Scoreboard testbench for fpu_int_to_float_seq with directed
//               vectors and hand-computed results.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fpu_int_to_float_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic [2:0]  in_rm;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_inexact_flag;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] f;
        logic        nx;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    logic prev_v = 1'b0;

    fpu_int_to_float_seq #(
        .BIAS         (127),
        .COARSE_SHIFT (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_int           (in_int),
        .in_rm            (in_rm),
        .in_signed        (in_signed),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_float        (out_float),
        .out_inexact_flag (out_inexact_flag)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got float=%h nx=%b", out_float, out_inexact_flag);
            end else begin
                if (!prev_v && q[0].lat >= 0) begin
                    checks++;
                    if (cyc - q[0].acc != q[0].lat) begin
                        failures++;
                        $display("FAIL latency got=%0d want=%0d (want float=%h)",
                                 cyc - q[0].acc, q[0].lat, q[0].f);
                    end
                end
                checks++;
                if (out_float !== q[0].f || out_inexact_flag !== q[0].nx) begin
                    failures++;
                    $display("FAIL result got float=%h nx=%b want float=%h nx=%b",
                             out_float, out_inexact_flag, q[0].f, q[0].nx);
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL in_ready_busy got=%b want=0", in_ready);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
        prev_v = rst ? 1'b0 : out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic convert(input logic [31:0] v, input logic sg, input logic [2:0] rm,
                           input logic [31:0] ef, input logic enx, input int lat);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout operand=%h got in_ready=0 want 1", v);
            return;
        end
        in_int    = v;
        in_signed = sg;
        in_rm     = rm;
        in_valid  = 1'b1;
        q.push_back('{ef, enx, lat, cyc + 1});
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 100) begin
            tick();
            n++;
        end
        if (q.size() != 0 || !in_ready) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got pending=%0d want 0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_int    = '0;
        in_rm     = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("reset_in_ready",  32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_float", out_float, 32'h0);
        chk("reset_nx",        32'(out_inexact_flag), 32'd0);
        rst = 1'b0;
        tick();

        // value, signed, rm, expected float, expected NX, latency
        convert(32'h00000001, 1'b1, 3'd0, 32'h3F800000, 1'b0, 12);
        convert(32'h80000000, 1'b1, 3'd0, 32'hCF000000, 1'b0, 2);
        convert(32'h80000000, 1'b0, 3'd0, 32'h4F000000, 1'b0, 2);
        convert(32'h7FFFFFFF, 1'b1, 3'd0, 32'h4F000000, 1'b1, 3);
        convert(32'h7FFFFFFF, 1'b1, 3'd1, 32'h4EFFFFFF, 1'b1, 3);
        convert(32'h7FFFFFFF, 1'b1, 3'd5, 32'h4EFFFFFF, 1'b1, 3);
        convert(32'h01000001, 1'b1, 3'd0, 32'h4B800000, 1'b1, 6);
        convert(32'h01000001, 1'b1, 3'd3, 32'h4B800001, 1'b1, 6);
        convert(32'h01000001, 1'b1, 3'd4, 32'h4B800001, 1'b1, 6);
        convert(32'h01000001, 1'b1, 3'd2, 32'h4B800000, 1'b1, 6);
        convert(32'hFFFFFFFF, 1'b1, 3'd2, 32'hBF800000, 1'b0, 12);
        convert(32'hFFFFFFFF, 1'b0, 3'd0, 32'h4F800000, 1'b1, 2);
        convert(32'hFFFFFFFF, 1'b0, 3'd1, 32'h4F7FFFFF, 1'b1, 2);
        convert(32'h80000001, 1'b1, 3'd2, 32'hCF000000, 1'b1, 3);
        convert(32'h80000001, 1'b1, 3'd3, 32'hCEFFFFFF, 1'b1, 3);
        convert(32'h00000000, 1'b1, 3'd0, 32'h00000000, 1'b0, 1);
        drain();

        // Back-pressure, with an operand offered while busy that must be ignored.
        out_ready = 1'b0;
        convert(32'h00000003, 1'b0, 3'd0, 32'h40400000, 1'b0, 11);
        in_int   = 32'h00000005;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        repeat (5) tick();
        out_ready = 1'b1;
        drain();

        // Reset in the middle of normalisation.
        convert(32'h00000001, 1'b1, 3'd0, 32'h3F800000, 1'b0, 12);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready",  32'(in_ready), 32'd1);
        q.delete();
        #1;
        rst = 1'b0;
        tick();
        convert(32'h01000001, 1'b1, 3'd0, 32'h4B800000, 1'b1, 6);
        drain();
        repeat (3) tick();
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
